// File: rtl/cam_fb_writer.sv
// cam_fb_writer: stores the camera RGB565 stream into a double-banked
// framebuffer, optionally decimating 2:1 in x and y. Completed frames are
// handed to the VGA reader by swapping banks. A short or overlong frame is
// discarded, and the next frame overwrites the same bank.
//
// Stream handshake: pixel_valid_i is a one-cycle qualifier with no
// backpressure. Every pulse seen in ACTIVE is consumed on that clock.
// wr_en_o is likewise a one-cycle strobe that the RAM must accept.
module cam_fb_writer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 1,
  parameter int ADDR_W   = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              setup_done_i,
  input  logic              frame_valid_i,
  input  logic              pixel_valid_i,
  input  logic [15:0]       pixel_i,
  output logic              wr_en_o,
  output logic [ADDR_W:0]   wr_addr_o,
  output logic [15:0]       wr_data_o,
  output logic              display_bank_o,
  output logic              frame_done_o,
  output logic              frame_err_o
);

  localparam int unsigned FRAME_PIX = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = $clog2(FRAME_PIX + 2);
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W   = $clog2(V_ACTIVE + 1);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, ACTIVE} state_t;

  state_t             state, state_nxt;
  logic               fv_q;
  logic               wbank;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [ADDR_W-1:0]  addr;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic sof, eof, pix_take, keep, x_last, frame_good;
  logic wr_en_d, done_d, err_d;

  // Start of frame needs frame_valid low on the previous cycle, so a
  // frame already in progress when we arrive is never joined.
  assign sof        = (state == WAIT_SOF) && frame_valid_i && !fv_q;
  assign eof        = (state == ACTIVE) && !frame_valid_i && fv_q;
  assign pix_take   = (state == ACTIVE) && setup_done_i && pixel_valid_i;
  assign x_last     = (x == X_W'(H_ACTIVE - 1));
  assign keep       = pix_take && (y < Y_W'(V_ACTIVE)) &&
                      ((DECIM == 0) || (!x[0] && !y[0]));
  // Count including a pixel arriving on the end-of-frame cycle; saturates
  // one past a full frame so overlong frames stay distinguishable.
  assign cnt_nxt    = (pix_take && (cnt != CNT_W'(FRAME_PIX + 1))) ?
                      cnt + 1'b1 : cnt;
  assign frame_good = (cnt_nxt == CNT_W'(FRAME_PIX));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; losing setup_done aborts from any state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (setup_done_i) state_nxt = WAIT_SOF;
      WAIT_SOF: if (sof)          state_nxt = ACTIVE;
      ACTIVE:   if (eof)          state_nxt = WAIT_SOF;
      default:                    state_nxt = IDLE;
    endcase
    if (!setup_done_i) state_nxt = IDLE;
  end

  // Output decode: write and frame-result strobes, registered below
  always_comb begin
    wr_en_d = keep;
    done_d  = eof && setup_done_i && frame_good;
    err_d   = eof && setup_done_i && !frame_good;
  end

  // Datapath: pixel position, address, count, bank and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fv_q           <= 1'b1;
      wbank          <= 1'b0;
      x              <= '0;
      y              <= '0;
      addr           <= '0;
      cnt            <= '0;
      wr_en_o        <= 1'b0;
      wr_addr_o      <= '0;
      wr_data_o      <= '0;
      display_bank_o <= 1'b1;
      frame_done_o   <= 1'b0;
      frame_err_o    <= 1'b0;
    end else begin
      fv_q         <= frame_valid_i;
      wr_en_o      <= wr_en_d;
      frame_done_o <= done_d;
      frame_err_o  <= err_d;
      if (keep) begin
        wr_data_o <= pixel_i;
        wr_addr_o <= {wbank, addr};
        addr      <= addr + 1'b1;
      end
      if (sof) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
        cnt  <= '0;
      end else if (pix_take) begin
        cnt <= cnt_nxt;
        if (x_last) begin
          x <= '0;
          if (y != Y_W'(V_ACTIVE)) y <= y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (done_d) begin
        wbank          <= ~wbank;
        display_bank_o <= wbank;
      end
    end
  end

endmodule

// File: tb/tb_cam_fb_writer.sv
// Bench for cam_fb_writer: a DECIM=1 and a DECIM=0 instance share one
// camera stream on an 8x4 frame. Expected writes and frame results come
// from a frame-level model of the storage rules.
module tb_cam_fb_writer;
  localparam int H  = 8;
  localparam int V  = 4;
  localparam int AW = 5;
  localparam int W  = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, setup_done, frame_valid, pixel_valid;
  logic [15:0] pixel;

  logic          wr_en1, disp1, done1, err1;
  logic [AW:0]   wr_addr1;
  logic [15:0]   wr_data1;
  logic          wr_en0, disp0, done0, err0;
  logic [AW:0]   wr_addr0;
  logic [15:0]   wr_data0;

  cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(1), .ADDR_W(AW)) dut1 (
    .clk_i(clk), .rst_i(rst), .setup_done_i(setup_done),
    .frame_valid_i(frame_valid), .pixel_valid_i(pixel_valid), .pixel_i(pixel),
    .wr_en_o(wr_en1), .wr_addr_o(wr_addr1), .wr_data_o(wr_data1),
    .display_bank_o(disp1), .frame_done_o(done1), .frame_err_o(err1)
  );

  cam_fb_writer #(.H_ACTIVE(H), .V_ACTIVE(V), .DECIM(0), .ADDR_W(AW)) dut0 (
    .clk_i(clk), .rst_i(rst), .setup_done_i(setup_done),
    .frame_valid_i(frame_valid), .pixel_valid_i(pixel_valid), .pixel_i(pixel),
    .wr_en_o(wr_en0), .wr_addr_o(wr_addr0), .wr_data_o(wr_data0),
    .display_bank_o(disp0), .frame_done_o(done0), .frame_err_o(err0)
  );

  // Scoreboard state
  logic [W-1:0] exp_q1[$], exp_q0[$], got_q1[$], got_q0[$];
  logic [15:0]  pix_q[$];
  int got_done1 = 0, got_err1 = 0, got_done0 = 0, got_err0 = 0;
  int exp_done1 = 0, exp_err1 = 0, exp_done0 = 0, exp_err0 = 0;
  bit m_wb1, m_disp1, m_wb0, m_disp0;
  int checks = 0;
  int failures = 0;

  // Monitor: capture RAM writes and frame pulses mid-cycle
  always @(negedge clk) begin
    if (wr_en1) got_q1.push_back({wr_addr1, wr_data1});
    if (wr_en0) got_q0.push_back({wr_addr0, wr_data0});
    if (done1) got_done1++;
    if (err1)  got_err1++;
    if (done0) got_done0++;
    if (err0)  got_err0++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Pixel i of a frame is stored when it lies inside the frame and, when
  // decimating, sits on an even column of an even line.
  function automatic bit kept(input int i, input int decim);
    int px, py;
    px = i % H;
    py = i / H;
    return (py < V) && (decim == 0 || (px % 2 == 0 && py % 2 == 0));
  endfunction

  // Frame-level model: stored pixels go to consecutive addresses of the
  // current write bank; a full-size frame swaps banks, anything else errors.
  task automatic model_frame(input int n, input bit evaluate);
    int a1, a0;
    a1 = 0;
    a0 = 0;
    for (int i = 0; i < n; i++) begin
      if (kept(i, 1)) begin
        exp_q1.push_back({m_wb1, AW'(a1), pix_q[i]});
        a1++;
      end
      if (kept(i, 0)) begin
        exp_q0.push_back({m_wb0, AW'(a0), pix_q[i]});
        a0++;
      end
    end
    if (evaluate) begin
      if (n == H * V) begin
        exp_done1++; m_disp1 = m_wb1; m_wb1 = ~m_wb1;
        exp_done0++; m_disp0 = m_wb0; m_wb0 = ~m_wb0;
      end else begin
        exp_err1++;
        exp_err0++;
      end
    end
  endtask

  // Drive one frame of n pixels; the frame may end together with the last
  // pixel, after it, or not at all (left open for an abort).
  task automatic send_frame(input int n, input bit use_index, input bit fall_with_last,
                            input bit end_frame);
    logic [15:0] v;
    pix_q.delete();
    frame_valid = 1'b1;
    tick;
    tick;
    for (int i = 0; i < n; i++) begin
      v = use_index ? 16'(i) : 16'($urandom);
      pix_q.push_back(v);
      pixel_valid = 1'b1;
      pixel = v;
      if (end_frame && fall_with_last && i == n - 1) frame_valid = 1'b0;
      tick;
      chk("lat_d1", {31'd0, wr_en1}, {31'd0, kept(i, 1)});
      chk("lat_d0", {31'd0, wr_en0}, {31'd0, kept(i, 0)});
      pixel_valid = 1'b0;
      tick;
      chk("pulse_d1", {31'd0, wr_en1}, 32'd0);
      chk("pulse_d0", {31'd0, wr_en0}, 32'd0);
      repeat ($urandom_range(0, 1)) tick;
    end
    if (end_frame && !fall_with_last) frame_valid = 1'b0;
    if (end_frame) repeat (4) tick;
    model_frame(n, end_frame);
  endtask

  task automatic verify(input string tag);
    chk({tag, " nwr_d1"}, got_q1.size(), exp_q1.size());
    while (got_q1.size() > 0 && exp_q1.size() > 0)
      chk({tag, " wr_d1"}, 32'(got_q1.pop_front()), 32'(exp_q1.pop_front()));
    got_q1.delete();
    exp_q1.delete();
    chk({tag, " nwr_d0"}, got_q0.size(), exp_q0.size());
    while (got_q0.size() > 0 && exp_q0.size() > 0)
      chk({tag, " wr_d0"}, 32'(got_q0.pop_front()), 32'(exp_q0.pop_front()));
    got_q0.delete();
    exp_q0.delete();
    chk({tag, " done_d1"}, got_done1, exp_done1);
    chk({tag, " err_d1"},  got_err1,  exp_err1);
    chk({tag, " disp_d1"}, {31'd0, disp1}, {31'd0, m_disp1});
    chk({tag, " done_d0"}, got_done0, exp_done0);
    chk({tag, " err_d0"},  got_err0,  exp_err0);
    chk({tag, " disp_d0"}, {31'd0, disp0}, {31'd0, m_disp0});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " wr_en"},   {31'd0, wr_en1} | {31'd0, wr_en0}, 32'd0);
    chk({tag, " addr_d1"}, 32'(wr_addr1), 32'd0);
    chk({tag, " addr_d0"}, 32'(wr_addr0), 32'd0);
    chk({tag, " data_d1"}, 32'(wr_data1), 32'd0);
    chk({tag, " data_d0"}, 32'(wr_data0), 32'd0);
    chk({tag, " disp_d1"}, {31'd0, disp1}, 32'd1);
    chk({tag, " disp_d0"}, {31'd0, disp0}, 32'd1);
    chk({tag, " pulses"},  {28'd0, done1, err1, done0, err0}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    setup_done = 1'b0;
    frame_valid = 1'b0;
    pixel_valid = 1'b0;
    pixel = 16'h0;
    m_wb1 = 1'b0; m_disp1 = 1'b1;
    m_wb0 = 1'b0; m_disp0 = 1'b1;

    // Reset state
    repeat (3) tick;
    check_reset_outputs("reset");
    rst = 1'b0;
    tick;
    setup_done = 1'b1;
    repeat (3) tick;

    // Frame 1: index pixels into bank 0
    send_frame(H * V, 1'b1, 1'b0, 1'b1);
    verify("t1");
    chk("t1 disp_is_0", {31'd0, disp1}, 32'd0);

    // Frame 2: bank 1, frame ends together with the last pixel
    send_frame(H * V, 1'b0, 1'b1, 1'b1);
    verify("t2");
    chk("t2 disp_is_1", {31'd0, disp1}, 32'd1);

    // Short frame, then a good frame into the same bank
    send_frame(20, 1'b0, 1'b0, 1'b1);
    verify("t3 short");
    send_frame(H * V, 1'b0, 1'b0, 1'b1);
    verify("t3 good");

    // Overlong frame
    send_frame(H * V + 4, 1'b0, 1'b0, 1'b1);
    verify("t4");

    // Setup completes while a frame is already running
    setup_done = 1'b0;
    repeat (3) tick;
    frame_valid = 1'b1;
    repeat (2) tick;
    setup_done = 1'b1;
    repeat (3) tick;
    for (int i = 0; i < 5; i++) begin
      pixel_valid = 1'b1;
      pixel = 16'($urandom);
      tick;
      chk("t5 no_write", {31'd0, wr_en1} | {31'd0, wr_en0}, 32'd0);
      pixel_valid = 1'b0;
      tick;
    end
    frame_valid = 1'b0;
    repeat (3) tick;
    verify("t5 midjoin");
    send_frame(H * V, 1'b0, 1'b1, 1'b1);
    verify("t5 good");

    // Reset in the middle of a frame
    send_frame(10, 1'b0, 1'b0, 1'b0);
    repeat (2) tick;
    verify("t6 partial");
    rst = 1'b1;
    tick;
    check_reset_outputs("t6 rst");
    rst = 1'b0;
    frame_valid = 1'b0;
    m_wb1 = 1'b0; m_disp1 = 1'b1;
    m_wb0 = 1'b0; m_disp0 = 1'b1;
    repeat (3) tick;
    send_frame(H * V, 1'b1, 1'b0, 1'b1);
    verify("t6 after");

    // Random mix of good, short and overlong frames
    for (int k = 0; k < 8; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    n = H * V;
        2:       n = $urandom_range(1, H * V - 1);
        default: n = $urandom_range(H * V + 1, H * V + 8);
      endcase
      send_frame(n, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
      verify("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
